tt_uart_core: RTL



---
 rtl/tt_uart_pkg.sv | 29 ++
 rtl/tt_uart_sync.sv | 42 ++++
 rtl/tt_uart_core.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tt_uart_pkg.sv
// tt_uart_pkg: state codes and shared constants
// for the console UART core.
package tt_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_HUNT,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAITHI
  } rx_state_e;

  localparam int PHASE_W = 4;

  // mid-bit sample index inside one oversampled bit
  function automatic logic [PHASE_W-1:0] mid_index(
    input int os
  );
    return PHASE_W'(os / 2 - 1);
  endfunction

endpackage

// File: rtl/tt_uart_sync.sv
// tt_uart_sync: flop-chain synchroniser, optionally
// reduced to a one-clk pulse on the rising edge.
module tt_uart_sync #(
  parameter int STAGES  = 2,
  parameter bit EDGE    = 1'b1,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  generate
    if (EDGE) begin : g_edge
      logic last;

      always_ff @(posedge clk) begin
        if (reset) begin
          last <= RST_VAL;
        end else begin
          last <= chain[STAGES-1];
        end
      end

      assign q = chain[STAGES-1] & ~last;
    end else begin : g_level
      assign q = chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/tt_uart_core.sv
// tt_uart_core: 8N1-style UART behind the console
// controller, req/ack handshakes on both directions.
module tt_uart_core
  import tt_uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_clk,
  input  logic                 rx_clk,
  input  logic                 tx_req,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ack,
  output logic                 tx_empty,
  output logic                 tx_out,
  input  logic                 rx_in,
  input  logic                 rx_req,
  output logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_ferr,
  output logic                 rx_overrun
);

  localparam int TXC_MAX =
    (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int TXC_W = $clog2(TXC_MAX + 1);
  localparam int RXB_W = $clog2(DATA_BITS);

  localparam logic [TXC_W-1:0] TX_DLAST =
    TXC_W'(DATA_BITS);
  localparam logic [TXC_W-1:0] TX_SLAST =
    TXC_W'(STOP_BITS);
  localparam logic [RXB_W-1:0] RX_BLAST =
    RXB_W'(DATA_BITS - 1);
  localparam logic [PHASE_W-1:0] PH_LAST =
    PHASE_W'(OVERSAMPLE - 1);
  localparam logic [PHASE_W-1:0] PH_MID =
    mid_index(OVERSAMPLE);

  logic tx_tick;
  logic rx_tick;
  logic rx_s;

  tt_uart_sync #(
    .STAGES (SYNC_STAGES),
    .EDGE   (1'b1),
    .RST_VAL(1'b0)
  ) u_tx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (tx_clk),
    .q    (tx_tick)
  );

  tt_uart_sync #(
    .STAGES (SYNC_STAGES),
    .EDGE   (1'b1),
    .RST_VAL(1'b0)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx_clk),
    .q    (rx_tick)
  );

  tt_uart_sync #(
    .STAGES (SYNC_STAGES),
    .EDGE   (1'b0),
    .RST_VAL(1'b1)
  ) u_line_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx_in),
    .q    (rx_s)
  );

  // transmitter
  tx_state_e            tx_state;
  tx_state_e            tx_state_n;
  logic [DATA_BITS-1:0] tx_buf;
  logic [DATA_BITS-1:0] tx_buf_n;
  logic [TXC_W-1:0]     tx_cnt;
  logic [TXC_W-1:0]     tx_cnt_n;
  logic                 tx_out_n;
  logic                 tx_ack_n;
  logic                 tx_empty_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_buf   <= '0;
      tx_cnt   <= '0;
      tx_out   <= 1'b1;
      tx_ack   <= 1'b0;
      tx_empty <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_buf   <= tx_buf_n;
      tx_cnt   <= tx_cnt_n;
      tx_out   <= tx_out_n;
      tx_ack   <= tx_ack_n;
      tx_empty <= tx_empty_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_buf_n   = tx_buf;
    tx_cnt_n   = tx_cnt;
    tx_out_n   = tx_out;
    tx_ack_n   = tx_ack;
    tx_empty_n = tx_empty;
    if (!tx_req) begin
      tx_ack_n = 1'b0;
    end
    unique case (tx_state)
      TX_IDLE: begin
        if (tx_req && !tx_ack && tx_empty) begin
          tx_buf_n   = tx_data;
          tx_ack_n   = 1'b1;
          tx_empty_n = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_out_n   = 1'b0;
          tx_cnt_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          // one tick past the last data bit opens the stop bit
          if (tx_cnt == TX_DLAST) begin
            tx_out_n   = 1'b1;
            tx_cnt_n   = TXC_W'(1);
            tx_state_n = TX_STOP;
          end else begin
            tx_out_n = tx_buf[0];
            tx_buf_n = {1'b0, tx_buf[DATA_BITS-1:1]};
            tx_cnt_n = tx_cnt + TXC_W'(1);
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (tx_cnt == TX_SLAST) begin
            tx_empty_n = 1'b1;
            tx_state_n = TX_IDLE;
          end else begin
            tx_cnt_n = tx_cnt + TXC_W'(1);
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // receiver
  rx_state_e            rx_state;
  rx_state_e            rx_state_n;
  logic [PHASE_W-1:0]   rx_ph;
  logic [PHASE_W-1:0]   rx_ph_n;
  logic [RXB_W-1:0]     rx_bit;
  logic [RXB_W-1:0]     rx_bit_n;
  logic [DATA_BITS-1:0] rx_shift;
  logic [DATA_BITS-1:0] rx_shift_n;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] hold_n;
  logic                 hold_ferr;
  logic                 hold_ferr_n;
  logic                 hold_ovr;
  logic                 hold_ovr_n;
  logic                 rx_empty_n;
  logic [DATA_BITS-1:0] rx_data_n;
  logic                 rx_ferr_n;
  logic                 rx_overrun_n;
  logic                 rx_ack_n;
  logic                 rx_accept;

  assign rx_accept = rx_req && !rx_ack && !rx_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= RX_HUNT;
      rx_ph      <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      hold       <= '0;
      hold_ferr  <= 1'b0;
      hold_ovr   <= 1'b0;
      rx_empty   <= 1'b1;
      rx_data    <= '0;
      rx_ferr    <= 1'b0;
      rx_overrun <= 1'b0;
      rx_ack     <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_ph      <= rx_ph_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      hold       <= hold_n;
      hold_ferr  <= hold_ferr_n;
      hold_ovr   <= hold_ovr_n;
      rx_empty   <= rx_empty_n;
      rx_data    <= rx_data_n;
      rx_ferr    <= rx_ferr_n;
      rx_overrun <= rx_overrun_n;
      rx_ack     <= rx_ack_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_ph_n      = rx_ph;
    rx_bit_n     = rx_bit;
    rx_shift_n   = rx_shift;
    hold_n       = hold;
    hold_ferr_n  = hold_ferr;
    hold_ovr_n   = hold_ovr;
    rx_empty_n   = rx_empty;
    rx_data_n    = rx_data;
    rx_ferr_n    = rx_ferr;
    rx_overrun_n = rx_overrun;
    rx_ack_n     = rx_ack;
    if (!rx_req) begin
      rx_ack_n = 1'b0;
    end
    if (rx_accept) begin
      rx_data_n    = hold;
      rx_ferr_n    = hold_ferr;
      rx_overrun_n = hold_ovr;
      hold_ovr_n   = 1'b0;
      rx_ack_n     = 1'b1;
      rx_empty_n   = 1'b1;
    end
    if (rx_tick) begin
      unique case (rx_state)
        RX_HUNT: begin
          if (!rx_s) begin
            rx_ph_n    = '0;
            rx_state_n = RX_START;
          end
        end
        RX_START: begin
          if (rx_ph == PH_MID) begin
            rx_ph_n    = '0;
            rx_bit_n   = '0;
            rx_state_n = rx_s ? RX_HUNT : RX_DATA;
          end else begin
            rx_ph_n = rx_ph + PHASE_W'(1);
          end
        end
        RX_DATA: begin
          rx_ph_n = rx_ph + PHASE_W'(1);
          if (rx_ph == PH_LAST) begin
            rx_shift_n =
              {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == RX_BLAST) begin
              rx_state_n = RX_STOP;
            end else begin
              rx_bit_n = rx_bit + RXB_W'(1);
            end
          end
        end
        RX_STOP: begin
          rx_ph_n = rx_ph + PHASE_W'(1);
          if (rx_ph == PH_LAST) begin
            hold_n      = rx_shift;
            hold_ferr_n = !rx_s;
            rx_empty_n  = 1'b0;
            // a char handed over this cycle is not lost
            if (!rx_empty && !rx_accept) begin
              hold_ovr_n = 1'b1;
            end
            rx_state_n = rx_s ? RX_HUNT : RX_WAITHI;
          end
        end
        RX_WAITHI: begin
          if (rx_s) begin
            rx_state_n = RX_HUNT;
          end
        end
        default: rx_state_n = RX_HUNT;
      endcase
    end
  end

endmodule
